// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
// Imported by the storage entry and the top-level register file.
package regfile_scoreboard_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NUM_DEF   = 64;
    localparam int REG_ZERO  = 0;
    localparam int FREG_BASE = 32;

    function automatic logic addr_ok(input int unsigned a, input int unsigned n);
        return a < n;
    endfunction

endpackage

// File: rtl/regfile_entry.sv
// One architectural register: a value flop plus its pending-write busy flop.
// Busy priority is flush, then claim (set), then write (clear).
module regfile_entry
    import regfile_scoreboard_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set,
    input  logic             flush,
    output logic [WIDTH-1:0] value,
    output logic             busy
);

    // Value register: load the winning write data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
        end else if (wr_en) begin
            value <= wr_data;
        end
    end

    // Busy flag: a squash beats a new owner, a new owner beats a completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (set) begin
            busy <= 1'b1;
        end else if (wr_en) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a busy-bit
// scoreboard used by issue for operand fetch and RAW/WAW hazard checks.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int NUM      = NUM_DEF,
    parameter  int NRD      = 3,
    parameter  int NWR      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_addr,
    output logic                 claim_stall,
    input  logic                 flush
);

    logic [NWR-1:0]   wr_ok;
    logic [NUM-1:0]   wr_hit;
    logic [WIDTH-1:0] wr_val [NUM];
    logic [WIDTH-1:0] val_q  [NUM];
    logic [NUM-1:0]   busy_q;
    logic [NUM-1:0]   claim_set;
    logic             claim_ok;

    // Inputs are ignored while reset is held, including the bypass path
    for (genvar p = 0; p < NWR; p++) begin : g_wok
        assign wr_ok[p] = rstn & wr_en[p]
                        & addr_ok(32'(wr_addr[p*AW +: AW]), NUM);
    end

    assign claim_ok = rstn & claim_en
                    & addr_ok(32'(claim_addr), NUM)
                    & ~((ZERO_REG != REG_ZERO) & (claim_addr == '0));

    // A write landing this cycle retires the old owner, so no WAW stall
    assign claim_stall = claim_ok & busy_q[claim_addr] & ~wr_hit[claim_addr];

    for (genvar i = 0; i < NUM; i++) begin : g_reg
        if (i < ZERO_REG) begin : g_zero
            assign wr_hit[i]    = 1'b0;
            assign wr_val[i]    = '0;
            assign val_q[i]     = '0;
            assign busy_q[i]    = 1'b0;
            assign claim_set[i] = 1'b0;
        end else begin : g_ent
            logic             hit;
            logic [WIDTH-1:0] val;

            // Highest-index write port targeting this register wins
            always_comb begin
                hit = 1'b0;
                val = '0;
                for (int p = 0; p < NWR; p++) begin
                    if (wr_ok[p] && (wr_addr[p*AW +: AW] == AW'(i))) begin
                        hit = 1'b1;
                        val = wr_data[p*WIDTH +: WIDTH];
                    end
                end
            end

            assign wr_hit[i]    = hit;
            assign wr_val[i]    = val;
            assign claim_set[i] = claim_ok & ~claim_stall
                                & (claim_addr == AW'(i));

            regfile_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clk     (clk),
                .rstn    (rstn),
                .wr_en   (hit),
                .wr_data (val),
                .set     (claim_set[i]),
                .flush   (flush),
                .value   (val_q[i]),
                .busy    (busy_q[i])
            );
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a = rd_addr[k*AW +: AW];

        // Zero/out-of-range reads first, then forwarding, then stored state
        always_comb begin
            d = '0;
            b = 1'b0;
            if (addr_ok(32'(a), NUM)
                && !((ZERO_REG != REG_ZERO) && (a == '0))) begin
                if ((BYPASS != 0) && wr_hit[a]) begin
                    d = wr_val[a];
                end else begin
                    d = val_q[a];
                    b = busy_q[a];
                end
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = d;
        assign rd_busy[k]                = b;
    end

endmodule
